sample_deserializer_mc: RTL and testbench

Multichannel byte-to-sample deserializer that sits between the pad-level byte interface (`uio_in` data, byte-valid strobe, unit select) and the bank of per-unit spike-detection processors. It is the parametrised successor to the fixed 2-byte MSB-then-LSB assembler:
- any byte-multiple sample width;
- selectable byte order;
- optional frame mode that auto-sequences units;
- valid/ready output handshake with overrun flagging;
- an inter-byte timeout that resynchronises a broken transfer.

---
 rtl/deser_pkg.sv | 17 +
 rtl/idle_timer.sv | 35 +++
 rtl/sample_deserializer_mc.sv | 170 +++++++++++++++++
 tb/tb_sample_deserializer_mc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the multichannel byte-to-sample deserializer.
package deser_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } deser_state_e;

    // Unit index width: at least one bit even for tiny unit counts.
    function automatic int unsigned sel_width(input int unsigned num_units);
        return (num_units <= 2) ? 1 : $clog2(num_units);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Counts enabled cycles while running without a clear; pulses expire when the
// count reaches TIMEOUT_CYCLES. A TIMEOUT_CYCLES of 0 disables expiry.
module idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q;

    // An accepted byte in the same cycle always beats expiry.
    assign expire = (TIMEOUT_CYCLES != 0) && run && ena && !clear &&
                    (cnt_q == CW'(TIMEOUT_CYCLES));

    // Idle counter: restarts on clear, when stopped, or once it has fired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            if (clear || !run || expire) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_deserializer_mc.sv
// Assembles byte strobes into DATA_WIDTH samples for one of NUM_UNITS units,
// with selectable byte order, auto unit sequencing, valid/ready output and
// an inter-byte timeout that drops broken transfers.
module sample_deserializer_mc
    import deser_pkg::*;
#(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned SEL_WIDTH      = sel_width(NUM_UNITS),
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic [SEL_WIDTH-1:0]  sel_in,
    input  logic                  mode_auto,
    input  logic                  msb_first,
    input  logic                  overrun_clr,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic [SEL_WIDTH-1:0]  sample_unit,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_done,
    output logic                  resync
);

    localparam int unsigned BYTES = DATA_WIDTH / BYTE_W;
    localparam int unsigned CNT_W = $clog2(BYTES + 1);

    deser_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      bcnt_q, bcnt_d;
    logic [SEL_WIDTH-1:0]  unit_q, unit_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  msb_q, msb_d;
    logic                  mode_q, mode_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_done_q, frame_done_d;
    logic                  resync_q, resync_d;
    logic                  byte_acc;
    logic                  expire;

    // MSB-first shifts left and appends; LSB-first shifts right and prepends.
    function automatic logic [DATA_WIDTH-1:0] shift_byte(input logic [DATA_WIDTH-1:0] acc,
                                                         input logic [7:0] b,
                                                         input logic msb);
        if (msb) begin
            return (acc << BYTE_W) | DATA_WIDTH'(b);
        end
        return (acc >> BYTE_W) | (DATA_WIDTH'(b) << (DATA_WIDTH - BYTE_W));
    endfunction

    assign byte_acc = ena && byte_valid && ((state_q != StHold) || sample_ready);

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .run    (state_q == StAccum),
        .clear  (byte_acc),
        .expire (expire)
    );

    // Next-state: FSM, accumulator, frame pointer, sticky overrun and pulses.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        bcnt_d       = bcnt_q;
        unit_d       = unit_q;
        ptr_d        = ptr_q;
        msb_d        = msb_q;
        mode_d       = mode_q;
        overrun_d    = overrun_q;
        frame_done_d = frame_done_q;
        resync_d     = resync_q;
        if (ena) begin
            frame_done_d = 1'b0;
            resync_d     = 1'b0;
            if (overrun_clr) begin
                overrun_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (!mode_auto) begin
                        ptr_d = '0;
                    end
                end
                StAccum: begin
                    if (!byte_valid && expire) begin
                        state_d = StIdle;
                        resync_d = 1'b1;
                    end
                end
                StHold: begin
                    if (sample_ready) begin
                        state_d = StIdle;
                        if (mode_q) begin
                            if (ptr_q == SEL_WIDTH'(NUM_UNITS - 1)) begin
                                ptr_d        = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                ptr_d = ptr_q + 1'b1;
                            end
                        end
                    end else if (byte_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            // First byte of a sample (from IDLE, or zero-bubble out of HOLD).
            if (byte_acc && (state_q != StAccum)) begin
                unit_d  = mode_auto ? ptr_d : sel_in;
                msb_d   = msb_first;
                mode_d  = mode_auto;
                acc_d   = shift_byte('0, byte_in, msb_first);
                bcnt_d  = CNT_W'(1);
                state_d = (BYTES == 1) ? StHold : StAccum;
            end else if (byte_acc) begin
                acc_d  = shift_byte(acc_q, byte_in, msb_q);
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_d == CNT_W'(BYTES)) begin
                    state_d = StHold;
                end
            end
        end
    end

    // State registers; ena low leaves every register as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            bcnt_q       <= '0;
            unit_q       <= '0;
            ptr_q        <= '0;
            msb_q        <= 1'b0;
            mode_q       <= 1'b0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            resync_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bcnt_q       <= bcnt_d;
            unit_q       <= unit_d;
            ptr_q        <= ptr_d;
            msb_q        <= msb_d;
            mode_q       <= mode_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            resync_q     <= resync_d;
        end
    end

    assign sample_out   = acc_q;
    assign sample_unit  = unit_q;
    assign sample_valid = (state_q == StHold);
    assign busy         = (state_q == StAccum);
    assign overrun      = overrun_q;
    assign frame_done   = frame_done_q;
    assign resync       = resync_q;

endmodule

// File: tb/tb_sample_deserializer_mc.sv
// Directed bench for sample_deserializer_mc: 4 units, 16-bit samples, timeout 10.
module tb_sample_deserializer_mc;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [1:0]  sel_in;
    logic        mode_auto;
    logic        msb_first;
    logic        overrun_clr;
    logic [15:0] sample_out;
    logic [1:0]  sample_unit;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        overrun;
    logic        frame_done;
    logic        resync;

    int n_checks = 0;
    int n_fail   = 0;

    sample_deserializer_mc #(
        .NUM_UNITS      (4),
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .sel_in       (sel_in),
        .mode_auto    (mode_auto),
        .msb_first    (msb_first),
        .overrun_clr  (overrun_clr),
        .sample_out   (sample_out),
        .sample_unit  (sample_unit),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun),
        .frame_done   (frame_done),
        .resync       (resync)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic handshake();
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (sample_out !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h want 0000", sample_out); end
        n_checks++; if (sample_unit !== 2'd0) begin n_fail++; $display("FAIL reset_unit: got %0d want 0", sample_unit); end
        n_checks++; if ({sample_valid, busy, overrun, frame_done, resync} !== 5'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {sample_valid, busy, overrun, frame_done, resync}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_select_mode();
        mode_auto = 1'b0; sel_in = 2'd2; msb_first = 1'b1; sample_ready = 1'b0;
        strobe(8'h12);
        n_checks++; if (busy !== 1'b1 || sample_valid !== 1'b0)
            begin n_fail++; $display("FAIL sel_first_byte: busy=%b valid=%b want 1 0", busy, sample_valid); end
        strobe(8'h34);
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL sel_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample_out !== 16'h1234) begin n_fail++; $display("FAIL sel_msb_out: got %h want 1234", sample_out); end
        n_checks++; if (sample_unit !== 2'd2) begin n_fail++; $display("FAIL sel_unit: got %0d want 2", sample_unit); end
        handshake();
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL sel_release: got %b want 0", sample_valid); end
        msb_first = 1'b0;
        strobe(8'h12);
        strobe(8'h34);
        n_checks++; if (sample_out !== 16'h3412 || sample_valid !== 1'b1)
            begin n_fail++; $display("FAIL sel_lsb_out: got %h/%b want 3412/1", sample_out, sample_valid); end
        handshake();
    endtask

    task automatic test_frame_wrap();
        logic [7:0]  b0, b1;
        logic [15:0] exp;
        int          fd_seen;
        fd_seen = 0;
        mode_auto = 1'b1; msb_first = 1'b1; sample_ready = 1'b1; sel_in = 2'd3;
        for (int p = 0; p < 4; p++) begin
            b0 = 8'(8'h10 + 2 * p);
            b1 = 8'(8'h11 + 2 * p);
            exp = {b0, b1};
            strobe(b0);
            if (frame_done === 1'b1) fd_seen++;
            strobe(b1);
            if (frame_done === 1'b1) fd_seen++;
            n_checks++; if (sample_valid !== 1'b1 || sample_out !== exp || sample_unit !== 2'(p))
                begin n_fail++; $display("FAIL frame_sample%0d: got %b/%h/u%0d want 1/%h/u%0d", p, sample_valid, sample_out, sample_unit, exp, p); end
        end
        n_checks++; if (fd_seen != 0) begin n_fail++; $display("FAIL frame_early_done: got %0d pulses want 0", fd_seen); end
        tick();
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
        tick();
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
        strobe(8'hE1);
        strobe(8'hE2);
        n_checks++; if (sample_unit !== 2'd0 || sample_out !== 16'hE1E2)
            begin n_fail++; $display("FAIL frame_after_wrap: got u%0d/%h want u0/e1e2", sample_unit, sample_out); end
        tick();
        sample_ready = 1'b0;
        mode_auto = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        sel_in = 2'd1; msb_first = 1'b1; sample_ready = 1'b0;
        strobe(8'hAB);
        strobe(8'hCD);
        strobe(8'hAA);
        n_checks++; if (sample_valid !== 1'b1 || sample_out !== 16'hABCD || sample_unit !== 2'd1)
            begin n_fail++; $display("FAIL ovr_hold: got %b/%h/u%0d want 1/abcd/u1", sample_valid, sample_out, sample_unit); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        overrun_clr = 1'b1;
        strobe(8'hBB);
        overrun_clr = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        n_checks++; if (overrun !== 1'b0 || sample_out !== 16'hABCD)
            begin n_fail++; $display("FAIL ovr_reclear: got %b/%h want 0/abcd", overrun, sample_out); end
    endtask

    task automatic test_back_to_back();
        // Still holding 0xABCD for unit 1; release and feed the next byte together.
        sel_in = 2'd1;
        sample_ready = 1'b1;
        strobe(8'h56);
        sample_ready = 1'b0;
        n_checks++; if (sample_valid !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0)
            begin n_fail++; $display("FAIL b2b_accept: got v%b b%b o%b want v0 b1 o0", sample_valid, busy, overrun); end
        strobe(8'h78);
        n_checks++; if (sample_valid !== 1'b1 || sample_out !== 16'h5678 || sample_unit !== 2'd1)
            begin n_fail++; $display("FAIL b2b_sample: got %b/%h/u%0d want 1/5678/u1", sample_valid, sample_out, sample_unit); end
        handshake();
    endtask

    task automatic test_timeout();
        int  waited;
        bit  seen;
        sel_in = 2'd3; msb_first = 1'b1;
        strobe(8'h9A);
        for (int i = 0; i < 9; i++) tick();
        n_checks++; if (busy !== 1'b1 || resync !== 1'b0)
            begin n_fail++; $display("FAIL to_early: got busy=%b resync=%b want 1 0", busy, resync); end
        seen = 0;
        waited = 0;
        while (!seen && waited < 4) begin
            tick();
            waited++;
            if (resync === 1'b1) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL to_resync: got no pulse want pulse"); end
        n_checks++; if (busy !== 1'b0 || sample_valid !== 1'b0)
            begin n_fail++; $display("FAIL to_discard: got busy=%b valid=%b want 0 0", busy, sample_valid); end
        tick();
        n_checks++; if (resync !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", resync); end
        strobe(8'h11);
        strobe(8'h22);
        n_checks++; if (sample_out !== 16'h1122 || sample_unit !== 2'd3 || sample_valid !== 1'b1)
            begin n_fail++; $display("FAIL to_recover: got %h/u%0d/%b want 1122/u3/1", sample_out, sample_unit, sample_valid); end
        handshake();
    endtask

    task automatic test_freeze_reset();
        int resync_seen;
        resync_seen = 0;
        sel_in = 2'd0; msb_first = 1'b1;
        strobe(8'hC3);
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            byte_in = 8'hFF;
            byte_valid = (i < 3);
            tick();
            if (resync === 1'b1) resync_seen++;
        end
        byte_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || resync_seen != 0 || sample_out !== 16'h00C3)
            begin n_fail++; $display("FAIL frz_hold: got busy=%b resyncs=%0d out=%h want 1 0 00c3", busy, resync_seen, sample_out); end
        ena = 1'b1;
        strobe(8'h3C);
        n_checks++; if (sample_valid !== 1'b1 || sample_out !== 16'hC33C)
            begin n_fail++; $display("FAIL frz_complete: got %b/%h want 1/c33c", sample_valid, sample_out); end
        handshake();
        strobe(8'h77);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || sample_out !== 16'h0000 || sample_valid !== 1'b0)
            begin n_fail++; $display("FAIL rst_async: got busy=%b out=%h valid=%b want 0 0000 0", busy, sample_out, sample_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({sample_valid, busy, overrun, frame_done, resync} !== 5'b0 || sample_unit !== 2'd0)
            begin n_fail++; $display("FAIL rst_after: got %b u%0d want 00000 u0", {sample_valid, busy, overrun, frame_done, resync}, sample_unit); end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; sel_in = 2'd0;
        mode_auto = 1'b0; msb_first = 1'b1; overrun_clr = 1'b0; sample_ready = 1'b0;
        test_reset();
        test_select_mode();
        test_frame_wrap();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_freeze_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
